// File: rtl/uart_str_tx.sv
// uart_str_tx: 8N1 UART transmitter for short ASCII strings, LSB first.
//
// A one-cycle request latches a right-aligned string buffer and a character
// count. Characters go out from byte (count-1) down to byte 0 with no idle
// gap between frames. Counts above MAXBYTES are clamped to MAXBYTES.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   en_uart    send request, sampled every cycle; ignored while busy
//   read_data  string buffer, byte k = bits [8k+7:8k]
//   nummax     number of characters to send (0 = just pulse tx_done)
//   uart_tx    serial line, idles high
//   tx_busy    high while a string is on the line
//   tx_done    one-cycle pulse after the last stop bit of a string
//
// All outputs are registered one cycle behind the state register, so a
// request sampled at edge N shows up on the line at edge N+1.
module uart_str_tx #(
    parameter int unsigned BAUD_DIV = 703,
    parameter int unsigned MAXBYTES = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_uart,
    input  logic [8*MAXBYTES-1:0] read_data,
    input  logic [5:0]            nummax,
    output logic                  uart_tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    localparam logic [15:0] TimerMax = 16'(BAUD_DIV - 1);
    localparam logic [5:0]  MaxChars = 6'(MAXBYTES);

    state_e                state_q, state_d;
    logic [15:0]           timer_q, timer_d;
    logic [2:0]            bitcnt_q, bitcnt_d;
    logic [3:0]            idx_q, idx_d;
    logic [8*MAXBYTES-1:0] shreg_q, shreg_d;
    logic [7:0]            bitsh_q, bitsh_d;
    logic                  done_ev_q, done_ev_d;
    logic                  uart_tx_q, uart_tx_d;
    logic                  tx_busy_q, tx_busy_d;
    logic                  tx_done_q, tx_done_d;

    logic                  bit_end;
    logic [3:0]            n_chars;
    logic [7:0]            cur_byte;

    assign bit_end = (timer_q == TimerMax);

    // Clamped character count for a new request.
    always_comb begin
        n_chars = nummax[3:0];
        if (nummax > MaxChars) begin
            n_chars = 4'(MAXBYTES);
        end
    end

    // Byte currently addressed by idx; indices past the buffer read as zero.
    always_comb begin
        cur_byte = 8'h00;
        for (int k = 0; k < int'(MAXBYTES); k++) begin
            if (idx_q == 4'(k)) begin
                cur_byte = shreg_q[8*k +: 8];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bitcnt_d  = bitcnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        bitsh_d   = bitsh_q;
        done_ev_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                timer_d  = 16'd0;
                bitcnt_d = 3'd0;
                if (en_uart) begin
                    if (nummax != 6'd0) begin
                        shreg_d = read_data;
                        idx_d   = n_chars - 4'd1;
                        state_d = StStart;
                    end else begin
                        // Empty string: acknowledge without touching the line.
                        done_ev_d = 1'b1;
                    end
                end
            end

            StStart: begin
                if (bit_end) begin
                    timer_d = 16'd0;
                    bitsh_d = cur_byte;
                    state_d = StData;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            StData: begin
                if (bit_end) begin
                    timer_d = 16'd0;
                    bitsh_d = {1'b0, bitsh_q[7:1]};
                    if (bitcnt_q == 3'd7) begin
                        bitcnt_d = 3'd0;
                        state_d  = StStop;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            StStop: begin
                if (bit_end) begin
                    timer_d = 16'd0;
                    if (idx_q == 4'd0) begin
                        done_ev_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        // Next character follows immediately, no idle gap.
                        idx_d   = idx_q - 4'd1;
                        state_d = StStart;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Registered outputs derived from the current state.
    always_comb begin
        uart_tx_d = 1'b1;
        unique case (state_q)
            StStart: uart_tx_d = 1'b0;
            StData:  uart_tx_d = bitsh_q[0];
            default: uart_tx_d = 1'b1;
        endcase
        tx_busy_d = (state_q != StIdle);
        tx_done_d = done_ev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            timer_q   <= 16'd0;
            bitcnt_q  <= 3'd0;
            idx_q     <= 4'd0;
            shreg_q   <= '0;
            bitsh_q   <= 8'h00;
            done_ev_q <= 1'b0;
            uart_tx_q <= 1'b1;
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bitcnt_q  <= bitcnt_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            bitsh_q   <= bitsh_d;
            done_ev_q <= done_ev_d;
            uart_tx_q <= uart_tx_d;
            tx_busy_q <= tx_busy_d;
            tx_done_q <= tx_done_d;
        end
    end

    assign uart_tx = uart_tx_q;
    assign tx_busy = tx_busy_q;
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_str_tx.sv
// Testbench for uart_str_tx. The reference model derives the expected line
// level for every cycle after a request directly from the string: frame j
// carries character j (byte n-1-j), each frame is start, 8 data bits LSB
// first, stop, B cycles per bit. The line is also decoded mid-bit and the
// recovered bytes compared against the expected character list.
module tb_uart_str_tx;

    localparam int B = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_uart;
    logic [79:0] read_data;
    logic [5:0]  nummax;
    logic        uart_tx;
    logic        tx_busy;
    logic        tx_done;

    int errors = 0;
    int checks = 0;

    uart_str_tx #(
        .BAUD_DIV(B),
        .MAXBYTES(10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_uart   (en_uart),
        .read_data (read_data),
        .nummax    (nummax),
        .uart_tx   (uart_tx),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    function automatic int clamp_n(input logic [5:0] m);
        return (m > 6'd10) ? 10 : int'(m);
    endfunction

    task automatic req_on(input logic [79:0] d, input logic [5:0] m);
        en_uart   = 1'b1;
        read_data = d;
        nummax    = m;
    endtask

    // Drop the request after its latch edge and scramble the inputs.
    task automatic req_off();
        @(negedge clk);
        en_uart   = 1'b0;
        read_data = {16'($urandom), $urandom, $urandom};
        nummax    = 6'($urandom);
    endtask

    // Entered at the negedge right after the latch edge N. Iteration c
    // samples after edge N+c. Returns at the negedge after N+n*10*B+1+tail.
    task automatic check_string(input string name, input logic [79:0] d,
                                input logic [5:0] m, input bit noise, input int tail);
        int n;
        int total;
        int nz;
        int line_bad, busy_bad, done_bad;
        int line_first, busy_first, done_first;
        logic [7:0] exp_q[$];
        logic [7:0] rx_q[$];
        logic [7:0] rx;
        n = clamp_n(m);
        total = n * 10 * B;
        nz = (noise && total > 2) ? int'($urandom_range(total - 2, 1)) : -10;
        line_bad = 0; busy_bad = 0; done_bad = 0;
        line_first = 0; busy_first = 0; done_first = 0;
        rx = 8'h00;
        for (int i = 0; i < n; i++) exp_q.push_back(d[8*(n-1-i) +: 8]);

        for (int c = 1; c <= total + 1 + tail; c++) begin
            int t, j, bp;
            logic [7:0] eb;
            logic e_line, e_busy, e_done;
            @(negedge clk);
            if (c == nz + 1) en_uart = 1'b0;
            t = c - 1;
            e_line = 1'b1;
            e_busy = 1'b0;
            e_done = (c == total + 1);
            bp = 0;
            if (c <= total) begin
                j  = t / (10 * B);
                bp = (t % (10 * B)) / B;
                eb = exp_q[j];
                e_busy = 1'b1;
                if (bp == 0) e_line = 1'b0;
                else if (bp <= 8) e_line = eb[bp-1];
                if ((t % B) == B / 2) begin
                    if (bp >= 1 && bp <= 8) rx[bp-1] = uart_tx;
                    else if (bp == 9) rx_q.push_back(rx);
                end
            end
            if (uart_tx !== e_line) begin
                if (line_bad == 0) line_first = c;
                line_bad++;
            end
            if (tx_busy !== e_busy) begin
                if (busy_bad == 0) busy_first = c;
                busy_bad++;
            end
            if (tx_done !== e_done) begin
                if (done_bad == 0) done_first = c;
                done_bad++;
            end
            // A foreign request while busy must be ignored.
            if (c == nz) req_on({16'($urandom), $urandom, $urandom}, 6'($urandom_range(63, 1)));
        end

        checks++;
        if (line_bad != 0) begin
            errors++;
            $display("FAIL %s uart_tx: %0d wrong cycles (first at cycle %0d), required 0",
                     name, line_bad, line_first);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL %s tx_busy: %0d wrong cycles (first at cycle %0d), required 0",
                     name, busy_bad, busy_first);
        end
        checks++;
        if (done_bad != 0) begin
            errors++;
            $display("FAIL %s tx_done: %0d wrong cycles (first at cycle %0d), required 0",
                     name, done_bad, done_first);
        end
        checks++;
        if (rx_q.size() != n) begin
            errors++;
            $display("FAIL %s byte count: got %0d, required %0d", name, rx_q.size(), n);
        end
        for (int i = 0; i < n && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s byte %0d: got %h, required %h", name, i, rx_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic send(input string name, input logic [79:0] d, input logic [5:0] m,
                        input bit noise, input int tail);
        @(negedge clk);
        req_on(d, m);
        req_off();
        check_string(name, d, m, noise, tail);
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0;
        en_uart = 1'b0;
        read_data = '0;
        nummax = 6'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({uart_tx, tx_busy, tx_done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_hold: got tx/busy/done=%b, required 100",
                     {uart_tx, tx_busy, tx_done});
        end
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if ({uart_tx, tx_busy, tx_done} !== 3'b100) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_idle: %0d cycles not idle, required 0", bad);
        end
    endtask

    task automatic test_three();
        send("three", 80'h2A3123, 6'd3, 1'b0, 3);
    endtask

    task automatic test_full();
        send("full", 80'h2A41_3038_2D32_5F56_3423, 6'd10, 1'b0, 3);
    endtask

    task automatic test_busy_clamp();
        send("busy_ignore", 80'h2A41_3038_2D32_5F56_3423, 6'd4, 1'b1, 2);
        send("clamp15", 80'h3132_3334_3536_3738_3930, 6'd15, 1'b1, 2);
        send("empty", 80'h2A3123, 6'd0, 1'b0, 10);
    endtask

    task automatic test_reset_mid();
        int bad;
        @(negedge clk);
        req_on(80'h2A3123, 6'd3);
        req_off();
        bad = 0;
        // Run into data bit 3 of the second character.
        for (int c = 1; c <= 10 * B + 4 * B + 1; c++) begin
            @(negedge clk);
            if (tx_done !== 1'b0) bad++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({uart_tx, tx_busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_mid_now: got tx/busy=%b, required 10", {uart_tx, tx_busy});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if ({uart_tx, tx_busy, tx_done} !== 3'b100) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: %0d cycles with activity or tx_done, required 0", bad);
        end
        send("after_reset", 80'h2A3123, 6'd3, 1'b0, 3);
    endtask

    task automatic test_back_to_back();
        send("b2b_first", 80'h2A3123, 6'd3, 1'b0, 0);
        // Now in the tx_done cycle of the first string.
        req_on(80'h2A3023, 6'd3);
        req_off();
        check_string("b2b_second", 80'h2A3023, 6'd3, 1'b0, 3);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            logic [79:0] d;
            logic [5:0] m;
            for (int b = 0; b < 10; b++) d[8*b +: 8] = 8'($urandom_range(126, 32));
            m = 6'($urandom_range(15, 1));
            send($sformatf("random%0d", k), d, m, 1'($urandom), 1);
        end
    endtask

    initial begin
        test_reset();
        test_three();
        test_full();
        test_busy_clamp();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
